regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-side front end of the pipeline's 32x32 register file. Merges the in-order writeback stream with results from a long-latency unit (load/divide), buffers the late results in a small FIFO, and drives the register file's `reg_wr`/`waddr`/`wdata` port. It also keeps a per-register pending scoreboard so decode can stall on outstanding long-latency destinations.

## Interface
- `DEPTH`, default 2: long-latency result FIFO entries, power of two, 2 to 8.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `wb_valid` in 1: the pipeline writeback has a result this cycle. It has priority and is never stalled.
- `wb_rd` in 5: pipeline destination register.
- `wb_data` in 32: pipeline result.
- `iss_valid` in 1: a long-latency op issues this cycle.
- `iss_rd` in 5: destination of the issuing op, which is marked pending.
- `lu_valid` in 1: the long-latency unit offers a result.
- `lu_ready` out 1: the FIFO can accept.
- `lu_rd` in 5: destination of the offered result.
- `lu_data` in 32: the offered result.
- `busy_raddr1`, `busy_raddr2` in 5: scoreboard query addresses.
- `busy1`, `busy2` out 1: the queried register is pending.
- `reg_wr` out 1: register file write enable.
- `waddr` out 5: register file write address.
- `wdata` out 32: register file write data.
- `stall_cnt` out 16: blocked-drain cycle count. Present always; see Configuration.

## Operation
- The FIFO holds {rd, data} pairs. It has read/write pointers plus an occupancy counter of 0..DEPTH.
- `lu_ready` = occupancy != DEPTH, taken from registered state only. There is no combinational path from any input to `lu_ready`.
- A push happens when `lu_valid` && `lu_ready`.
  - If `lu_rd` == 0, the result is accepted and discarded. It is not enqueued and no pending bit changes.
- The write port is combinational from current state and inputs:
  - If `wb_valid` && `wb_rd` != 0: `reg_wr`=1, `waddr`=`wb_rd`, `wdata`=`wb_data`. The FIFO does not pop.
  - Else, if the FIFO is non-empty: `reg_wr`=1, `waddr`/`wdata` = the FIFO head, and the head pops at the edge.
  - Else: `reg_wr`=0, `waddr`=0, `wdata`=0.
- `wb_valid` with `wb_rd`=0 is treated as no writeback, so the FIFO may drain that cycle.
- Scoreboard is a 32-bit `pending` vector. Bit 0 is hardwired to 0.
  - Set `pending[iss_rd]` on `iss_valid`, unless `iss_rd`=0.
  - Clear `pending[head.rd]` on a FIFO pop.
  - If a set and a clear hit the same register in the same cycle, the set wins.
- `busy1` = `pending[busy_raddr1]` and `busy2` = `pending[busy_raddr2]`, both combinational.
- Issue to an already-pending register is illegal. Decode stalls on `busy` before issuing. The block keeps the bit set and does not count.
- A pipeline write to a pending register is performed and leaves the pending bit unchanged. WAW ordering is owned by decode.

## Timing
- Pipeline writeback has zero added latency: same-cycle passthrough to the register file.
- A long-latency result is written no earlier than the cycle after its push. A push into an empty FIFO with no `wb_valid` is written the next cycle.
- Push and pop in the same cycle leave occupancy unchanged. Pointers wrap modulo DEPTH.
- With a full FIFO, `lu_ready` stays 0 even in a cycle where a pop occurs. It rises the cycle after.
- When the pending bit clears at the pop edge, the register file captures the data at that same edge. A read after the edge sees the new value, so no bypass is needed.
- While `reset` is low:
  - FIFO empty, pointers and occupancy 0.
  - `pending` = 0, so `busy1` = `busy2` = 0.
  - `reg_wr`=0, `waddr`=0, `wdata`=0; these are forced while reset is low.
  - `lu_ready`=1, `stall_cnt`=0.
- Reset asserted mid-operation discards all queued results and pending bits immediately.

## Configuration
- `WB_STALL_CNT_EN` defined:
  - `stall_cnt` increments each cycle in which the FIFO is non-empty and a valid pipeline writeback (`wb_valid` && `wb_rd` != 0) blocks the drain.
  - It saturates at 16'hFFFF and is cleared only by reset.
- Not defined: the counter logic is omitted and `stall_cnt` is tied to 0.

## Test plan
- Reset, then `wb_valid`=1, `wb_rd`=5, `wb_data`=32'hDEADBEEF -> `reg_wr`=1, `waddr`=5, `wdata`=32'hDEADBEEF in the same cycle; FIFO stays empty.
- `iss_valid`, `iss_rd`=7, then query `busy_raddr1`=7 -> `busy1`=1. Push {7, 32'h1234} with idle wb -> write of reg 7 the next cycle, and `busy1`=0 after that edge.
- Hold `wb_valid` with rd=3 for 4 cycles while pushing {8, 1} and {9, 2} -> `lu_ready`=0 after the 2nd push. Drains are reg 8 then reg 9 in the two cycles after wb drops. With `WB_STALL_CNT_EN`, `stall_cnt`=3 (FIFO non-empty in cycles 2–4).
- `lu_valid` with `lu_rd`=0 -> accepted, no write, occupancy 0. `iss_rd`=0 -> `pending` stays 0.
- Same cycle: pop of rd=4 and `iss_valid` with `iss_rd`=4 -> `busy` for reg 4 stays 1.
- Fill the FIFO, then assert `reset` low mid-drain -> `reg_wr`=0 immediately. After release, `lu_ready`=1, all `busy`=0, no further writes.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Write-side bus of the register file arbiter: writeback, issue, long-latency
// handshake, scoreboard query and the register file write port.
interface regfile_wb_arbiter_if;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic [4:0]  busy_raddr1;
    logic [4:0]  busy_raddr2;
    logic        busy1;
    logic        busy2;
    logic        reg_wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [15:0] stall_cnt;

    modport slave (
        input  wb_valid, wb_rd, wb_data,
        input  iss_valid, iss_rd,
        input  lu_valid, lu_rd, lu_data,
        input  busy_raddr1, busy_raddr2,
        output lu_ready, busy1, busy2,
        output reg_wr, waddr, wdata, stall_cnt
    );

    modport master (
        output wb_valid, wb_rd, wb_data,
        output iss_valid, iss_rd,
        output lu_valid, lu_rd, lu_data,
        output busy_raddr1, busy_raddr2,
        input  lu_ready, busy1, busy2,
        input  reg_wr, waddr, wdata, stall_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file write arbiter: pipeline writeback has priority, long-latency
// results queue in a FIFO and drain in idle slots; pending scoreboard for decode.
// Optional blocked-drain counter enabled by defining WB_STALL_CNT_EN.
module regfile_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } lu_entry_t;

    lu_entry_t     mem [DEPTH];
    lu_entry_t     head;
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] occ;
    logic [31:0]   pending, pending_nxt;
    logic          full, empty, push, pop, wb_hit;

    assign full  = (occ == CW'(DEPTH));
    assign empty = (occ == '0);
    assign head  = mem[rptr];

    // lu_ready depends on registered occupancy only, so a pop cannot open a slot
    // in the same cycle.
    assign bus.lu_ready = !full;

    assign wb_hit = bus.wb_valid && (bus.wb_rd != 5'd0);
    assign push   = bus.lu_valid && !full && (bus.lu_rd != 5'd0);
    assign pop    = !wb_hit && !empty;

    always_comb begin
        bus.reg_wr = 1'b0;
        bus.waddr  = 5'd0;
        bus.wdata  = 32'd0;
        if (reset) begin
            if (wb_hit) begin
                bus.reg_wr = 1'b1;
                bus.waddr  = bus.wb_rd;
                bus.wdata  = bus.wb_data;
            end else if (!empty) begin
                bus.reg_wr = 1'b1;
                bus.waddr  = head.rd;
                bus.wdata  = head.data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= '{rd: bus.lu_rd, data: bus.lu_data};
    end

    // Clear first, then set, so an issue to the register being retired wins.
    always_comb begin
        pending_nxt = pending;
        if (pop) pending_nxt[head.rd] = 1'b0;
        if (bus.iss_valid) pending_nxt[bus.iss_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pending <= '0;
        else        pending <= pending_nxt;
    end

    assign bus.busy1 = pending[bus.busy_raddr1];
    assign bus.busy2 = pending[bus.busy_raddr2];

`ifdef WB_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                  stall_q <= 16'd0;
        else if (wb_hit && !empty && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: priority, FIFO drain order, scoreboard
// set/clear, zero-register handling and mid-drain reset.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    regfile_wb_arbiter_if bus();

    regfile_wb_arbiter #(.DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef WB_STALL_CNT_EN
    localparam logic [31:0] STALL_EXP = 32'd3;
`else
    localparam logic [31:0] STALL_EXP = 32'd0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge; inputs change here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;
        bus.iss_valid = 0; bus.iss_rd = 0;
        bus.lu_valid = 0; bus.lu_rd = 0; bus.lu_data = 0;
        bus.busy_raddr1 = 0; bus.busy_raddr2 = 0;

        // Reset state, including the forced-idle write port.
        step(); step();
        bus.wb_valid = 1; bus.wb_rd = 5'd6; bus.wb_data = 32'h11;
        settle();
        chk("rst_reg_wr", 32'(bus.reg_wr), 32'd0);
        chk("rst_waddr", 32'(bus.waddr), 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        chk("rst_lu_ready", 32'(bus.lu_ready), 32'd1);
        chk("rst_busy1", 32'(bus.busy1), 32'd0);
        chk("rst_stall", 32'(bus.stall_cnt), 32'd0);
        bus.wb_valid = 0;
        step();
        reset = 1'b1;
        step();

        // Pipeline writeback passes through in the same cycle.
        bus.wb_valid = 1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF;
        settle();
        chk("wb_reg_wr", 32'(bus.reg_wr), 32'd1);
        chk("wb_waddr", 32'(bus.waddr), 32'd5);
        chk("wb_wdata", bus.wdata, 32'hDEADBEEF);
        step();
        bus.wb_valid = 0;
        settle();
        chk("wb_idle", 32'(bus.reg_wr), 32'd0);

        // Issue rd 7, then return its result.
        bus.iss_valid = 1; bus.iss_rd = 5'd7; bus.busy_raddr1 = 5'd7;
        settle();
        chk("iss_busy_before", 32'(bus.busy1), 32'd0);
        step();
        bus.iss_valid = 0;
        bus.lu_valid = 1; bus.lu_rd = 5'd7; bus.lu_data = 32'h1234;
        settle();
        chk("iss_busy_set", 32'(bus.busy1), 32'd1);
        chk("push_no_same_cycle_write", 32'(bus.reg_wr), 32'd0);
        step();
        bus.lu_valid = 0;
        settle();
        chk("drain7_reg_wr", 32'(bus.reg_wr), 32'd1);
        chk("drain7_waddr", 32'(bus.waddr), 32'd7);
        chk("drain7_wdata", bus.wdata, 32'h1234);
        chk("drain7_busy_held", 32'(bus.busy1), 32'd1);
        step();
        chk("drain7_busy_clear", 32'(bus.busy1), 32'd0);
        chk("drain7_done", 32'(bus.reg_wr), 32'd0);

        // Writeback blocks drain for 4 cycles while two results queue up.
        bus.wb_valid = 1; bus.wb_rd = 5'd3; bus.wb_data = 32'hAAAA;
        bus.lu_valid = 1; bus.lu_rd = 5'd8; bus.lu_data = 32'd1;
        settle();
        chk("blk_c1_waddr", 32'(bus.waddr), 32'd3);
        step();
        bus.lu_rd = 5'd9; bus.lu_data = 32'd2;
        settle();
        chk("blk_c2_ready", 32'(bus.lu_ready), 32'd1);
        chk("blk_c2_wdata", bus.wdata, 32'hAAAA);
        step();
        bus.lu_valid = 0;
        settle();
        chk("blk_c3_full", 32'(bus.lu_ready), 32'd0);
        step();
        settle();
        chk("blk_c4_waddr", 32'(bus.waddr), 32'd3);
        step();
        bus.wb_valid = 0;
        settle();
        chk("drain8_waddr", 32'(bus.waddr), 32'd8);
        chk("drain8_wdata", bus.wdata, 32'd1);
        chk("full_pop_ready_low", 32'(bus.lu_ready), 32'd0);
        step();
        chk("drain9_waddr", 32'(bus.waddr), 32'd9);
        chk("drain9_wdata", bus.wdata, 32'd2);
        chk("ready_after_pop", 32'(bus.lu_ready), 32'd1);
        step();
        chk("drain_empty", 32'(bus.reg_wr), 32'd0);
        chk("stall_cnt", 32'(bus.stall_cnt), STALL_EXP);

        // Register 0 results and issues are ignored.
        bus.lu_valid = 1; bus.lu_rd = 5'd0; bus.lu_data = 32'h55;
        settle();
        chk("rd0_ready", 32'(bus.lu_ready), 32'd1);
        step();
        bus.lu_valid = 0;
        bus.iss_valid = 1; bus.iss_rd = 5'd0;
        settle();
        chk("rd0_no_write", 32'(bus.reg_wr), 32'd0);
        step();
        bus.iss_valid = 0; bus.busy_raddr1 = 5'd0;
        settle();
        chk("rd0_not_busy", 32'(bus.busy1), 32'd0);
        chk("rd0_no_write2", 32'(bus.reg_wr), 32'd0);

        // Set wins over clear for register 4.
        bus.iss_valid = 1; bus.iss_rd = 5'd4; bus.busy_raddr2 = 5'd4;
        step();
        bus.iss_valid = 0;
        bus.lu_valid = 1; bus.lu_rd = 5'd4; bus.lu_data = 32'h44;
        step();
        bus.lu_valid = 0;
        bus.iss_valid = 1; bus.iss_rd = 5'd4;
        settle();
        chk("pop4_waddr", 32'(bus.waddr), 32'd4);
        chk("pop4_busy", 32'(bus.busy2), 32'd1);
        step();
        bus.iss_valid = 0;
        settle();
        chk("set_wins_busy", 32'(bus.busy2), 32'd1);
        chk("set_wins_empty", 32'(bus.reg_wr), 32'd0);

        // Pipeline write to a pending register keeps it pending.
        bus.wb_valid = 1; bus.wb_rd = 5'd4; bus.wb_data = 32'h99;
        settle();
        chk("wb_pend_waddr", 32'(bus.waddr), 32'd4);
        step();
        bus.wb_valid = 0;
        settle();
        chk("wb_pend_busy", 32'(bus.busy2), 32'd1);

        // Fill the FIFO, start draining, then reset mid-drain.
        bus.wb_valid = 1; bus.wb_rd = 5'd3; bus.wb_data = 32'h1;
        bus.lu_valid = 1; bus.lu_rd = 5'd10; bus.lu_data = 32'hA;
        step();
        bus.lu_rd = 5'd11; bus.lu_data = 32'hB;
        step();
        bus.lu_valid = 0; bus.wb_valid = 0;
        settle();
        chk("pre_rst_waddr", 32'(bus.waddr), 32'd10);
        reset = 1'b0;
        settle();
        chk("mid_rst_reg_wr", 32'(bus.reg_wr), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy2), 32'd0);
        chk("mid_rst_ready", 32'(bus.lu_ready), 32'd1);
        step();
        reset = 1'b1;
        step();
        bus.busy_raddr1 = 5'd10;
        settle();
        chk("post_rst_reg_wr", 32'(bus.reg_wr), 32'd0);
        chk("post_rst_ready", 32'(bus.lu_ready), 32'd1);
        chk("post_rst_busy1", 32'(bus.busy1), 32'd0);
        chk("post_rst_busy2", 32'(bus.busy2), 32'd0);
        chk("post_rst_stall", 32'(bus.stall_cnt), 32'd0);
        step();
        chk("post_rst_no_write", 32'(bus.reg_wr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
